// File: rtl/freq_meter.sv
// Square-wave frequency meter: counts synchronised rising edges of sig_in over
// back-to-back gate windows of GATE_CYCLES clocks and publishes each count with a strobe.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic [GATE_W-1:0]      gate_cnt_reg;
  logic [CNT_W-1:0]       edge_cnt_reg;
  logic                   sat_reg;

  logic                   rise;
  logic [CNT_W:0]         edge_sum;
  logic                   sum_sat;
  logic [CNT_W-1:0]       edge_next;
  logic                   window_end;
  logic                   abort;

  // One extra bit on the sum exposes the carry that marks saturation.
  always_comb begin
    rise      = sync_reg[SYNC_STAGES-1] & ~prev_reg;
    edge_sum  = {1'b0, edge_cnt_reg} + {{CNT_W{1'b0}}, rise};
    sum_sat   = edge_sum[CNT_W];
    edge_next = sum_sat ? CNT_MAX : edge_sum[CNT_W-1:0];
  end

  always_comb begin
    state_next = state_reg;
    window_end = 1'b0;
    abort      = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) state_next = MEASURE;
      end
      MEASURE: begin
        busy = 1'b1;
        // Dropping en wins over a coinciding window end: no strobe is issued.
        if (!en) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (gate_cnt_reg == GATE_LAST) begin
          window_end = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      sync_reg     <= '0;
      prev_reg     <= 1'b0;
      gate_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      sat_reg      <= 1'b0;
      freq         <= '0;
      freq_valid   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      prev_reg   <= sync_reg[SYNC_STAGES-1];
      state_reg  <= state_next;
      freq_valid <= 1'b0;
      if (state_reg == MEASURE && !abort) begin
        if (window_end) begin
          // The rise seen on the last gate cycle belongs to the ending window.
          freq         <= edge_next;
          overflow     <= sat_reg | sum_sat;
          freq_valid   <= 1'b1;
          gate_cnt_reg <= '0;
          edge_cnt_reg <= '0;
          sat_reg      <= 1'b0;
        end else begin
          gate_cnt_reg <= gate_cnt_reg + 1'b1;
          edge_cnt_reg <= edge_next;
          sat_reg      <= sat_reg | sum_sat;
        end
      end else begin
        gate_cnt_reg <= '0;
        edge_cnt_reg <= '0;
        sat_reg      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: two instances (8-bit and 5-bit counters, 100-cycle gate)
// share stimulus; a vector table covers steady rates, then hand sequences cover corner cases.
module tb_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nRST;
  logic       en;
  logic       sig_in;
  logic [7:0] freq_a;
  logic       valid_a, ovf_a, busy_a;
  logic [4:0] freq_b;
  logic       valid_b, ovf_b, busy_b;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .nRST(nRST), .en(en), .sig_in(sig_in),
    .freq(freq_a), .freq_valid(valid_a), .overflow(ovf_a), .busy(busy_a)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(5), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .nRST(nRST), .en(en), .sig_in(sig_in),
    .freq(freq_b), .freq_valid(valid_b), .overflow(ovf_b), .busy(busy_b)
  );

  int   checks   = 0;
  int   failures = 0;
  int   sig_period = 2;
  logic dc_level   = 1'b0;
  int   ph         = 0;

  // Square-wave generator: half high / half low per period; period 0 means DC.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (sig_period == 0) begin
        sig_in = dc_level;
      end else begin
        ph     = (ph + 1) % sig_period;
        sig_in = (ph < sig_period / 2);
      end
    end
  end

  typedef struct {
    int   period;
    logic level;
    int   exp_a;
    int   ovf_a;
    int   exp_b;
    int   ovf_b;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_a && n < 400);
  endtask

  initial begin
    vec_t vecs[6];
    int   n;
    int   seen;

    vecs[0] = '{10, 1'b0, 10, 0, 10, 0};
    vecs[1] = '{ 0, 1'b0,  0, 0,  0, 0};
    vecs[2] = '{ 0, 1'b1,  0, 0,  0, 0};
    vecs[3] = '{ 4, 1'b0, 25, 0, 25, 0};
    vecs[4] = '{20, 1'b0,  5, 0,  5, 0};
    vecs[5] = '{ 2, 1'b0, 50, 0, 31, 1};

    // Reset held with sig_in toggling every cycle.
    nRST = 1'b0;
    en   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset_outputs",
          int'({freq_a, valid_a, ovf_a, busy_a, freq_b, valid_b, ovf_b, busy_b}), 0);
    end

    for (int i = 0; i < 6; i++) begin
      en         = 1'b0;
      nRST       = 1'b0;
      sig_period = vecs[i].period;
      dc_level   = vecs[i].level;
      repeat (3) @(negedge clk);
      nRST = 1'b1;
      repeat (5) @(negedge clk);
      en = 1'b1;
      wait_strobe(n);
      chk($sformatf("v%0d_first_latency", i), n, 101);
      wait_strobe(n);
      chk($sformatf("v%0d_period", i), n, 100);
      chk($sformatf("v%0d_freq_a", i), int'(freq_a), vecs[i].exp_a);
      chk($sformatf("v%0d_ovf_a", i), int'(ovf_a), vecs[i].ovf_a);
      chk($sformatf("v%0d_freq_b", i), int'(freq_b), vecs[i].exp_b);
      chk($sformatf("v%0d_ovf_b", i), int'(ovf_b), vecs[i].ovf_b);
      @(negedge clk);
      chk($sformatf("v%0d_single_strobe", i), int'(valid_a), 0);
      $display("vector %0d period=%0d level=%0d freq_a=%0d ovf_a=%0d freq_b=%0d ovf_b=%0d",
               i, vecs[i].period, vecs[i].level, freq_a, ovf_a, freq_b, ovf_b);
    end

    // Saturated 5-bit instance recovers after the rate drops (en stays high).
    sig_period = 10;
    wait_strobe(n);
    wait_strobe(n);
    chk("recover_period", n, 100);
    chk("recover_freq_b", int'(freq_b), 10);
    chk("recover_ovf_b", int'(ovf_b), 0);
    chk("recover_freq_a", int'(freq_a), 10);
    $display("recover freq_b=%0d ovf_b=%0d", freq_b, ovf_b);

    // Abort in the middle of a window.
    repeat (50) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy_a), 0);
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (valid_a) seen++;
    end
    chk("abort_no_strobe", seen, 0);
    chk("abort_freq_kept", int'(freq_a), 10);
    en = 1'b1;
    wait_strobe(n);
    chk("abort_restart_latency", n, 101);
    chk("abort_restart_freq", int'(freq_a == 8'd9 || freq_a == 8'd10), 1);
    $display("abort restart latency=%0d freq_a=%0d", n, freq_a);

    // One-cycle reset pulse at gate cycle 60 with en held high.
    repeat (60) @(negedge clk);
    nRST = 1'b0;
    @(negedge clk);
    chk("midreset_outputs",
        int'({freq_a, valid_a, ovf_a, busy_a, freq_b, valid_b, ovf_b, busy_b}), 0);
    nRST = 1'b1;
    wait_strobe(n);
    chk("midreset_latency", n, 101);
    wait_strobe(n);
    chk("midreset_period", n, 100);
    chk("midreset_freq", int'(freq_a), 10);
    $display("midreset latency ok freq_a=%0d", freq_a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
